// File: rtl/regfile_write_master.sv
// regfile_write_master: write-side initiator for the 8-entry register file.
// Queues write requests in a small FIFO and issues them one per cycle.
// Runs two sequences on demand: a zero-fill of every entry (CLEAR), and a
// read-back sweep (VERIFY) that compares each entry against a shadow copy
// of what this block believes the regfile holds.
module regfile_write_master #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              clear_start,
    input  logic              verify_start,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int FA    = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        VERIFY
    } state_t;

    state_t state;

    // FIFO pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [FA:0]       fifo_wr_ptr;
    logic [FA:0]       fifo_rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Sequence pointer and the shadow copy of the regfile contents.
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] next_ptr;
    logic [DATA_W-1:0] shadow [DEPTH];
    logic              mismatch;
    logic              start_clear;
    logic              start_verify;

    assign fifo_empty = (fifo_wr_ptr == fifo_rd_ptr);
    assign fifo_full  = (fifo_wr_ptr[FA] != fifo_rd_ptr[FA]) &&
                        (fifo_wr_ptr[FA-1:0] == fifo_rd_ptr[FA-1:0]);
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign head_addr  = fifo_addr[fifo_rd_ptr[FA-1:0]];
    assign head_data  = fifo_data[fifo_rd_ptr[FA-1:0]];

    assign busy         = !fifo_empty || wr_valid || (state != IDLE);
    // Clear has priority; starts arriving while busy are simply dropped.
    assign start_clear  = clear_start && !busy;
    assign start_verify = verify_start && !clear_start && !busy;

    assign next_ptr = ptr + ADDR_W'(1);
    assign mismatch = (rd_data != shadow[ptr]);

    // FIFO occupancy pointers; a full FIFO refuses a push even while popping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
        end else begin
            if (push) fifo_wr_ptr <= fifo_wr_ptr + (FA+1)'(1);
            if (pop)  fifo_rd_ptr <= fifo_rd_ptr + (FA+1)'(1);
        end
    end

    // FIFO storage needs no reset: entries are only read once written.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[fifo_wr_ptr[FA-1:0]] <= req_addr;
            fifo_data[fifo_wr_ptr[FA-1:0]] <= req_data;
        end
    end

    // Main sequencer: issues queued writes in IDLE, runs the CLEAR and VERIFY sweeps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_addr  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
            for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        wr_valid          <= 1'b1;
                        wr_addr           <= head_addr;
                        wr_data           <= head_data;
                        shadow[head_addr] <= head_data;
                    end else if (start_clear) begin
                        state    <= CLEAR;
                        ptr      <= '0;
                        wr_valid <= 1'b1;
                        wr_addr  <= '0;
                        wr_data  <= '0;
                    end else if (start_verify) begin
                        state    <= VERIFY;
                        ptr      <= '0;
                        rd_addr  <= '0;
                        err      <= 1'b0;
                        err_addr <= '0;
                        wr_valid <= 1'b0;
                    end else begin
                        wr_valid <= 1'b0;
                    end
                end
                CLEAR: begin
                    shadow[ptr] <= '0;
                    if (ptr == LAST_ADDR) begin
                        state    <= IDLE;
                        ptr      <= '0;
                        wr_valid <= 1'b0;
                    end else begin
                        ptr      <= next_ptr;
                        wr_addr  <= next_ptr;
                        wr_valid <= 1'b1;
                        done     <= (next_ptr == LAST_ADDR);
                    end
                end
                VERIFY: begin
                    if (mismatch && !err) begin
                        err      <= 1'b1;
                        err_addr <= ptr;
                    end
                    if (ptr == LAST_ADDR) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr     <= next_ptr;
                        rd_addr <= next_ptr;
                        done    <= (next_ptr == LAST_ADDR);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_master.sv
// tb_regfile_write_master: scoreboard bench for regfile_write_master with a
// behavioural regfile that can be made to return a corrupted entry.
module tb_regfile_write_master;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       clear_start = 1'b0;
    logic       verify_start = 1'b0;
    logic       wr_valid;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] err_addr;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_exp_t;

    typedef struct {
        logic       err;
        logic [2:0] err_addr;
    } done_exp_t;

    wr_exp_t   exp_wr[$];
    done_exp_t exp_done[$];
    wr_exp_t   mon_wr;
    done_exp_t pend_done;
    bit        pend = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] regs [8];
    logic       corrupt_en = 1'b0;

    regfile_write_master #(.DATA_W(8), .ADDR_W(3), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .clear_start(clear_start), .verify_start(verify_start),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err), .err_addr(err_addr)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural regfile: reset to zero, write on wr_valid, combinational read.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (wr_valid) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (corrupt_en && rd_addr == 3'd4) ? 8'h3D : regs[rd_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Present one request and hold it until accepted; leaves req_valid high.
    task automatic applyStimulus(input logic [2:0] a, input logic [7:0] d,
                                 output int acc_cyc, output bit rdy_first);
        bit accepted = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        rdy_first = req_ready;
        acc_cyc   = -1;
        for (int n = 0; n < 100 && !accepted; n++) begin
            if (req_ready) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
            @(posedge clock);
            #1;
        end
        if (!accepted) checkOutput("req_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic dropRequest();
        req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit idle = 1'b0;
        for (int n = 0; n < 300 && !idle; n++) begin
            if (!busy) idle = 1'b1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        if (!idle) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic startSeq(input bit c, input bit v);
        clear_start  = c;
        verify_start = v;
        @(posedge clock);
        #1;
        clear_start  = 1'b0;
        verify_start = 1'b0;
    endtask

    task automatic expectClearWrites();
        for (int a = 0; a < 8; a++) exp_wr.push_back('{addr: 3'(a), data: 8'h00, cyc: -1});
    endtask

    task automatic expectDone(input logic e, input logic [2:0] ea);
        exp_done.push_back('{err: e, err_addr: ea});
    endtask

    // Monitor: pops expected writes and done results as the DUT presents them.
    always @(negedge clock) begin
        if (reset) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                checkOutput("verify_err", {31'd0, err}, {31'd0, pend_done.err});
                checkOutput("verify_err_addr", {29'd0, err_addr}, {29'd0, pend_done.err_addr});
                pend = 1'b0;
            end
            if (wr_valid) begin
                if (exp_wr.size() == 0) begin
                    checkOutput("unexpected_write", {29'd0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    checkOutput("wr_addr", {29'd0, wr_addr}, {29'd0, mon_wr.addr});
                    checkOutput("wr_data", {24'd0, wr_data}, {24'd0, mon_wr.data});
                    if (mon_wr.cyc >= 0) checkOutput("wr_latency", cyc, mon_wr.cyc);
                end
            end
            if (done) begin
                checkOutput("busy_during_done", {31'd0, busy}, 32'd1);
                if (exp_done.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    pend_done = exp_done.pop_front();
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  c0;
        int  acc;
        bit  rdy;

        // Reset state
        @(posedge clock);
        @(posedge clock);
        #1;
        checkOutput("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        checkOutput("rst_wr_addr", {29'd0, wr_addr}, 32'd0);
        checkOutput("rst_wr_data", {24'd0, wr_data}, 32'd0);
        checkOutput("rst_rd_addr", {29'd0, rd_addr}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_err_addr", {29'd0, err_addr}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Three back-to-back requests: first write two cycles after first accept
        applyStimulus(3'd2, 8'hA1, c0, rdy);
        checkOutput("t1_ready0", {31'd0, rdy}, 32'd1);
        exp_wr.push_back('{addr: 3'd2, data: 8'hA1, cyc: c0 + 2});
        applyStimulus(3'd5, 8'hB2, acc, rdy);
        checkOutput("t1_ready1", {31'd0, rdy}, 32'd1);
        exp_wr.push_back('{addr: 3'd5, data: 8'hB2, cyc: c0 + 3});
        applyStimulus(3'd7, 8'hC3, acc, rdy);
        checkOutput("t1_ready2", {31'd0, rdy}, 32'd1);
        exp_wr.push_back('{addr: 3'd7, data: 8'hC3, cyc: c0 + 4});
        dropRequest();
        waitIdle();

        // Requests held during VERIFY: FIFO fills after 4, rest wait for IDLE
        expectDone(1'b0, 3'd0);
        startSeq(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'(i), 8'h10 + 8'(i), acc, rdy);
            exp_wr.push_back('{addr: 3'(i), data: 8'h10 + 8'(i), cyc: -1});
            if (i == 3) checkOutput("t2_ready_full", {31'd0, req_ready}, 32'd0);
            if (i == 4) checkOutput("t2_ready_5th", {31'd0, rdy}, 32'd0);
        end
        dropRequest();
        waitIdle();

        // Fill with 0x55, clear to zero, then verify clean
        for (int a = 0; a < 8; a++) begin
            applyStimulus(3'(a), 8'h55, acc, rdy);
            exp_wr.push_back('{addr: 3'(a), data: 8'h55, cyc: -1});
        end
        dropRequest();
        waitIdle();
        expectClearWrites();
        expectDone(1'b0, 3'd0);
        startSeq(1'b1, 1'b0);
        waitIdle();
        expectDone(1'b0, 3'd0);
        startSeq(1'b0, 1'b1);
        waitIdle();

        // Corrupted entry 4 is flagged; rd_addr sweeps the whole file
        applyStimulus(3'd4, 8'h3C, acc, rdy);
        exp_wr.push_back('{addr: 3'd4, data: 8'h3C, cyc: -1});
        dropRequest();
        waitIdle();
        corrupt_en = 1'b1;
        expectDone(1'b1, 3'd4);
        startSeq(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("t4_rd_addr_sweep", {29'd0, rd_addr}, k);
            @(posedge clock);
            #1;
        end
        waitIdle();
        corrupt_en = 1'b0;
        expectDone(1'b0, 3'd0);
        startSeq(1'b0, 1'b1);
        waitIdle();

        // Simultaneous starts: only CLEAR runs
        expectClearWrites();
        expectDone(1'b0, 3'd0);
        startSeq(1'b1, 1'b1);
        waitIdle();
        repeat (12) begin
            @(posedge clock);
            #1;
        end

        // Reset in the 4th CLEAR cycle aborts it without a done pulse
        exp_wr.push_back('{addr: 3'd0, data: 8'h00, cyc: -1});
        exp_wr.push_back('{addr: 3'd1, data: 8'h00, cyc: -1});
        exp_wr.push_back('{addr: 3'd2, data: 8'h00, cyc: -1});
        startSeq(1'b1, 1'b0);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        #1;
        checkOutput("t6_wr_valid", {31'd0, wr_valid}, 32'd0);
        checkOutput("t6_wr_addr", {29'd0, wr_addr}, 32'd0);
        checkOutput("t6_wr_data", {24'd0, wr_data}, 32'd0);
        checkOutput("t6_done", {31'd0, done}, 32'd0);
        checkOutput("t6_busy", {31'd0, busy}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        expectClearWrites();
        expectDone(1'b0, 3'd0);
        startSeq(1'b1, 1'b0);
        waitIdle();
        repeat (4) begin
            @(posedge clock);
            #1;
        end

        checkOutput("exp_wr_drained", exp_wr.size(), 32'd0);
        checkOutput("exp_done_drained", exp_done.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
